// File: rtl/sdram_cmd_arbiter.sv
// N-port SDRAM command arbiter. It picks one FIFO head per cycle using urgency,
// row-hit and write-streak tiers, with round-robin inside each tier, into a registered command slot.
module sdram_cmd_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDR_W        = 25,
  parameter int DATA_W        = 16,
  parameter int ROW_LSB       = 10,
  parameter int ROW_W         = 15,
  parameter int USEDW_W       = 8,
  parameter int URGENT_THRESH = 200,
  parameter int STARVE_LIMIT  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
  input  logic [NUM_PORTS*USEDW_W-1:0]  req_usedw,
  output logic [NUM_PORTS-1:0]          req_pop,
  input  logic                          row_close,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_write,
  output logic [ADDR_W-1:0]             cmd_addr,
  output logic [DATA_W-1:0]             cmd_data,
  output logic [$clog2(NUM_PORTS)-1:0]  cmd_port
);

  localparam int PORT_W   = $clog2(NUM_PORTS);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [USEDW_W-1:0]  URGENT_T   = USEDW_W'(URGENT_THRESH);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0]  addr_a  [NUM_PORTS];
  logic [DATA_W-1:0]  data_a  [NUM_PORTS];
  logic [USEDW_W-1:0] usedw_a [NUM_PORTS];
  logic [ROW_W-1:0]   row_a   [NUM_PORTS];

  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
  logic [DATA_W-1:0]   cmd_data_q,  cmd_data_d;
  logic [PORT_W-1:0]   cmd_port_q,  cmd_port_d;
  logic [PORT_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic                last_write_q, last_write_d;
  logic                row_valid_q,  row_valid_d;
  logic [ROW_W-1:0]    present_row_q, present_row_d;
  logic [STARVE_W-1:0] starve_q [NUM_PORTS];
  logic [STARVE_W-1:0] starve_d [NUM_PORTS];

  logic                 slot_free;
  logic                 grant_found;
  logic [PORT_W-1:0]    grant_idx;
  logic [NUM_PORTS-1:0] urg, hit, t_hit_wr, t_hit_rd, t_wr, t_rd, sel_mask;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      data_a[i]  = req_data[i*DATA_W +: DATA_W];
      usedw_a[i] = req_usedw[i*USEDW_W +: USEDW_W];
      row_a[i]   = addr_a[i][ROW_LSB +: ROW_W];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    urg = '0;
    hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit[i] = row_valid_q && (row_a[i] == present_row_q);
      urg[i] = req_valid[i] && ((usedw_a[i] > URGENT_T) || (starve_q[i] >= STARVE_MAX));
    end
    t_hit_wr = req_valid & hit & req_write & {NUM_PORTS{last_write_q}};
    t_hit_rd = req_valid & hit & ~req_write;
    t_wr     = req_valid & req_write;
    t_rd     = req_valid & ~req_write;
    if (|urg)           sel_mask = urg;
    else if (|t_hit_wr) sel_mask = t_hit_wr;
    else if (|t_hit_rd) sel_mask = t_hit_rd;
    else if (|t_wr)     sel_mask = t_wr;
    else                sel_mask = t_rd;
  end

  // Round-robin scan of the winning tier, starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      int idx;
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_found && sel_mask[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PORT_W'(idx);
      end
    end
  end

  assign slot_free = ~cmd_valid_q | cmd_ready;
  assign req_pop   = (slot_free && grant_found && !rst) ? (NUM_PORTS'(1) << grant_idx) : '0;

  always_comb begin
    cmd_valid_d   = cmd_valid_q;
    cmd_write_d   = cmd_write_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    cmd_port_d    = cmd_port_q;
    rr_ptr_d      = rr_ptr_q;
    last_write_d  = last_write_q;
    present_row_d = present_row_q;
    row_valid_d   = row_valid_q & ~row_close;
    for (int i = 0; i < NUM_PORTS; i++) starve_d[i] = starve_q[i];

    if (slot_free) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!req_valid[i] || (grant_found && grant_idx == PORT_W'(i)))
          starve_d[i] = '0;
        else if (starve_q[i] < STARVE_MAX)
          starve_d[i] = starve_q[i] + 1'b1;
      end
      if (grant_found) begin
        cmd_valid_d   = 1'b1;
        cmd_write_d   = req_write[grant_idx];
        cmd_addr_d    = addr_a[grant_idx];
        cmd_data_d    = data_a[grant_idx];
        cmd_port_d    = grant_idx;
        rr_ptr_d      = (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        last_write_d  = req_write[grant_idx];
        present_row_d = row_a[grant_idx];
        row_valid_d   = 1'b1;
      end else begin
        cmd_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; the starve array is
  // a handful of flops, so it is reset along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      cmd_port_q    <= '0;
      rr_ptr_q      <= '0;
      last_write_q  <= 1'b1;
      row_valid_q   <= 1'b0;
      present_row_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) starve_q[i] <= '0;
    end else begin
      cmd_valid_q   <= cmd_valid_d;
      cmd_write_q   <= cmd_write_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      cmd_port_q    <= cmd_port_d;
      rr_ptr_q      <= rr_ptr_d;
      last_write_q  <= last_write_d;
      row_valid_q   <= row_valid_d;
      present_row_q <= present_row_d;
      for (int i = 0; i < NUM_PORTS; i++) starve_q[i] <= starve_d[i];
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_port  = cmd_port_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Bench for sdram_cmd_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a tier/score reference model.
module tb_sdram_cmd_arbiter;

  localparam int NP = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int UW = 8;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req_valid, req_write, req_pop;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_data;
  logic [NP*UW-1:0] req_usedw;
  logic             row_close, cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_data;
  logic [1:0]       cmd_port;

  // Port heads as the bench sees them.
  bit          h_valid [NP];
  bit          h_write [NP];
  logic [AW-1:0] h_addr [NP];
  logic [DW-1:0] h_data [NP];
  logic [UW-1:0] h_usedw [NP];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit            m_valid = 0, m_write = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_port = 0;
  int            m_rr = 0;
  bit            m_last_write = 1, m_row_valid = 0;
  logic [14:0]   m_row = '0;
  int            m_starve [NP];

  sdram_cmd_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ROW_LSB(10), .ROW_W(15),
    .USEDW_W(UW), .URGENT_THRESH(200), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .req_usedw(req_usedw), .req_pop(req_pop),
    .row_close(row_close),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_port(cmd_port)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req_valid[p]            = h_valid[p];
      req_write[p]            = h_write[p];
      req_addr[p*AW +: AW]    = h_addr[p];
      req_data[p*DW +: DW]    = h_data[p];
      req_usedw[p*UW +: UW]   = h_usedw[p];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic [14:0] row, input logic [9:0] col);
    return {row, col};
  endfunction

  // Each valid port gets a score tier*NP + distance from rr; the lowest score wins.
  function automatic int model_grant();
    int best;
    int best_score;
    best = -1;
    best_score = 1 << 30;
    if (rst || (m_valid && !cmd_ready)) return -1;
    for (int p = 0; p < NP; p++) begin
      int tier;
      int score;
      bit hit;
      if (h_valid[p]) begin
        hit = m_row_valid && (h_addr[p][24:10] == m_row);
        if (int'(h_usedw[p]) > 200 || m_starve[p] >= SL) tier = 0;
        else if (hit && h_write[p] && m_last_write)      tier = 1;
        else if (hit && !h_write[p])                     tier = 2;
        else if (h_write[p])                             tier = 3;
        else                                             tier = 4;
        score = tier * NP + ((p - m_rr + NP) % NP);
        if (score < best_score) begin
          best_score = score;
          best = p;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_write = 0; m_addr = '0; m_data = '0; m_port = 0;
      m_rr = 0; m_last_write = 1; m_row_valid = 0; m_row = '0;
      for (int p = 0; p < NP; p++) m_starve[p] = 0;
    end else begin
      int g;
      bit free;
      g = model_grant();
      free = !m_valid || cmd_ready;
      if (row_close) m_row_valid = 0;
      if (free) begin
        for (int p = 0; p < NP; p++) begin
          if (!h_valid[p] || p == g) m_starve[p] = 0;
          else if (m_starve[p] < SL) m_starve[p] = m_starve[p] + 1;
        end
        if (g >= 0) begin
          m_valid = 1; m_write = h_write[g]; m_addr = h_addr[g]; m_data = h_data[g];
          m_port = g; m_rr = (g + 1) % NP; m_last_write = h_write[g];
          m_row = h_addr[g][24:10]; m_row_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    int g;
    logic [NP-1:0] exp_pop;
    check("pop_onehot0", 64'($onehot0(req_pop)), 64'd1);
    if (rst) begin
      check("rst_pop", 64'(req_pop), 64'd0);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    end else begin
      g = model_grant();
      exp_pop = (g >= 0) ? (NP'(1) << g) : '0;
      check("req_pop", 64'(req_pop), 64'(exp_pop));
      check("cmd_valid", 64'(cmd_valid), 64'(m_valid));
      if (m_valid) begin
        check("cmd_write", 64'(cmd_write), 64'(m_write));
        check("cmd_addr", 64'(cmd_addr), 64'(m_addr));
        check("cmd_data", 64'(cmd_data), 64'(m_data));
        check("cmd_port", 64'(cmd_port), 64'(m_port));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ports();
    for (int p = 0; p < NP; p++) begin
      h_valid[p] = 0; h_write[p] = 0; h_addr[p] = '0; h_data[p] = '0; h_usedw[p] = '0;
    end
  endtask

  task automatic set_port(input int p, input bit w, input logic [14:0] row, input logic [7:0] usedw);
    h_valid[p] = 1;
    h_write[p] = w;
    h_addr[p]  = mk_addr(row, 10'(p));
    h_data[p]  = 16'($urandom);
    h_usedw[p] = usedw;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    logic [AW-1:0] held_addr;
    bit free;
    rst = 1;
    cmd_ready = 0;
    row_close = 0;
    clear_ports();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    check("reset_cmd_write", 64'(cmd_write), 64'd0);
    check("reset_cmd_addr", 64'(cmd_addr), 64'd0);
    check("reset_cmd_data", 64'(cmd_data), 64'd0);
    check("reset_cmd_port", 64'(cmd_port), 64'd0);

    // Reset mid-stream while the command is stalled.
    set_port(0, 0, 15'h33, 8'd5);
    tick();
    check("stall_setup_valid", 64'(cmd_valid), 64'd1);
    tick();
    #2 rst = 1;
    #1;
    check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("midrst_pop", 64'(req_pop), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    cmd_ready = 1;
    for (int p = 0; p < NP; p++) set_port(p, 0, 15'(16'h100 + p), 8'd10);
    at_neg();
    check("first_grant_pop", 64'(req_pop), 64'b0001);
    tick();
    check("first_grant_port", 64'(cmd_port), 64'd0);

    // Round-robin with row_close every cycle; each popped head moves to a fresh row.
    do_reset();
    row_close = 1;
    for (int p = 0; p < NP; p++) set_port(p, 0, 15'(16'h100 + p), 8'd10);
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("rr_pop", 64'(req_pop), 64'(1 << (k % NP)));
      tick();
      check("rr_port", 64'(cmd_port), 64'(k % NP));
      h_addr[k % NP] = mk_addr(15'(16'h200 + k), 10'(k % NP));
    end
    row_close = 0;

    // Row hit tiers.
    do_reset();
    clear_ports();
    set_port(1, 1, 15'h12, 8'd10);
    at_neg();
    check("hit_setup_pop", 64'(req_pop), 64'b0010);
    tick();
    clear_ports();
    set_port(0, 0, 15'h55, 8'd10);
    set_port(2, 1, 15'h12, 8'd10);
    set_port(3, 0, 15'h12, 8'd10);
    at_neg();
    check("hit_t1_pop", 64'(req_pop), 64'b0100);
    tick();
    h_valid[2] = 0;
    at_neg();
    check("hit_t2_pop", 64'(req_pop), 64'b1000);
    tick();
    h_valid[3] = 0;
    at_neg();
    check("hit_rest_pop", 64'(req_pop), 64'b0001);
    tick();

    // Urgency threshold: 201 is urgent, 200 is not.
    for (int p = 0; p < 3; p++) set_port(p, 1, 15'h55, 8'd100);
    set_port(3, 0, 15'h77, 8'd201);
    at_neg();
    check("urgent_201_pop", 64'(req_pop), 64'b1000);
    tick();
    set_port(3, 0, 15'h78, 8'd200);
    at_neg();
    check("urgent_200_pop", 64'(req_pop), 64'b0001);
    tick();

    // Starvation: port 1 wins on its 5th arbitration cycle.
    clear_ports();
    tick();
    set_port(0, 1, 15'h55, 8'd10);
    set_port(1, 0, 15'h99, 8'd10);
    for (int k = 0; k < SL; k++) begin
      at_neg();
      check("starve_stream_pop", 64'(req_pop), 64'b0001);
      tick();
    end
    at_neg();
    check("starve_grant_pop", 64'(req_pop), 64'b0010);
    tick();

    // Backpressure: command holds, no pops, starve counters frozen.
    cmd_ready = 0;
    h_valid[1] = 0;
    set_port(2, 0, 15'hAA, 8'd10);
    held_addr = mk_addr(15'h99, 10'd1);
    for (int k = 0; k < 10; k++) begin
      at_neg();
      check("bp_pop", 64'(req_pop), 64'd0);
      check("bp_port", 64'(cmd_port), 64'd1);
      check("bp_addr", 64'(cmd_addr), 64'(held_addr));
      tick();
    end
    cmd_ready = 1;
    at_neg();
    check("bp_release_pop", 64'(req_pop), 64'b0001);
    tick();
    check("bp_release_port", 64'(cmd_port), 64'd0);
    check("bp_release_write", 64'(cmd_write), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      cmd_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++) begin
        logic [7:0] u;
        case ($urandom_range(0, 4))
          0: u = 8'd199;
          1: u = 8'd200;
          2: u = 8'd201;
          default: u = 8'($urandom_range(0, 190));
        endcase
        set_port(p, 1'($urandom_range(0, 1)), 15'(16'h10 + $urandom_range(0, 3)), u);
        h_addr[p][9:0] = 10'($urandom);
        h_valid[p] = ($urandom_range(0, 2) != 0);
      end
      free = !m_valid || cmd_ready;
      row_close = free && ($urandom_range(0, 7) == 0);
      tick();
    end
    row_close = 0;
    clear_ports();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
